regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 32, register data width; ADDRESS_WIDTH, default 5, register address width; STARVE_LIMIT, default 4, maximum consecutive blocked cycles for a pending I/O write.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wb_we  in  1  CPU writeback write enable.
- wb_addr  in  ADDRESS_WIDTH  CPU writeback destination register.
- wb_data  in  DATA_WIDTH  CPU writeback data.
- io_valid  in  1  external I/O write request.
- io_addr  in  ADDRESS_WIDTH  I/O destination register.
- io_data  in  DATA_WIDTH  I/O write data.
- io_ready  out  1  I/O request accepted this cycle (combinational).
- cpu_stall  out  1  CPU shall hold wb_* this cycle (combinational).
- busy  out  1  clear sequence in progress (registered).
- we3  out  1  register file write enable (registered).
- ad3  out  ADDRESS_WIDTH  register file write address (registered).
- wd3  out  DATA_WIDTH  register file write data (registered).

Function
REQ-003 SHALL implement two states: CLEAR and RUN; rst forces CLEAR with clear counter = 1.
REQ-004 CLEAR: each cycle SHALL register we3=1, ad3=counter, wd3=0, then increment the counter; after issuing address 2^ADDRESS_WIDTH-1, SHALL go to RUN.
REQ-005 CLEAR: busy=1, cpu_stall=1, io_ready=0; wb_* and io_* ignored; wait counter held at 0.
REQ-006 RUN: wb_req = wb_we && wb_addr != 0; io_req = io_valid && io_addr != 0.
REQ-007 RUN, io_valid && io_addr == 0: io_ready=1 in that cycle, no write, wait counter cleared.
REQ-008 RUN normal priority: wb_req wins; io_ready=1 only when io_req && !wb_req.
REQ-009 Wait counter (width ceil(log2(STARVE_LIMIT+1))): increments each cycle io_req is not granted; clears on io grant or when io_req is low.
REQ-010 Force: when io_req && wait counter == STARVE_LIMIT, io SHALL be granted (io_ready=1), cpu_stall=1, wb write not performed that cycle.
REQ-011 Outside CLEAR and force, cpu_stall=0; wb writes are never dropped except to x0.
REQ-012 Granted write in cycle N SHALL appear on we3/ad3/wd3 in cycle N+1 (1-cycle latency); cycles without a grant register we3=0, ad3/wd3 hold their previous values.
REQ-013 Same-address contention SHALL follow REQ-008/010 unchanged; no merging.
REQ-014 At most one write SHALL be issued per cycle; we3 SHALL never be 1 with ad3 == 0.
REQ-015 An io request SHALL be treated as completed only in a cycle where io_valid && io_ready; io_* SHALL be sampled in that cycle.

Reset
REQ-016 rst=1 on a clock edge SHALL set state=CLEAR, counter=1, wait counter=0, we3=0, ad3=0, wd3=0, busy=1.
REQ-017 rst asserted mid-CLEAR or mid-RUN SHALL restart the clear at address 1; a pending io request is not accepted while rst=1 or during CLEAR.
REQ-018 During rst=1, io_ready=0 and cpu_stall=1.

Verification
REQ-019 Release rst -> 31 consecutive cycles with we3=1, ad3=1..31, wd3=0, busy=1; then busy=0, cpu_stall=0.
REQ-020 RUN, wb_we=1, wb_addr=5, wb_data=0xDEADBEEF -> next cycle we3=1, ad3=5, wd3=0xDEADBEEF.
REQ-021 RUN, wb_we=1 continuously (addr 3), io_valid=1 io_addr=31 io_data=0x1, STARVE_LIMIT=4 -> io_ready=0 for 4 cycles, 5th cycle io_ready=1 and cpu_stall=1, next cycle ad3=31 wd3=0x1; following cycle ad3=3.
REQ-022 wb_we=1 wb_addr=0 -> we3 stays 0; io_valid=1 io_addr=0 -> io_ready=1 same cycle, we3 stays 0.
REQ-023 rst pulsed when clear counter = 10 -> clear restarts at ad3=1 and busy lasts a full 31 cycles.
REQ-024 wb_we=0, io_valid=1 io_addr=7 io_data=0xA5 -> io_ready=1 same cycle, next cycle we3=1 ad3=7 wd3=0xA5.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register-file write port arbiter: zero-fills registers 1..N-1 after reset, then
// arbitrates CPU writeback against an external I/O writer with a starvation guard.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_we,
  input  logic [ADDRESS_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0]    wb_data,
  input  logic                     io_valid,
  input  logic [ADDRESS_WIDTH-1:0] io_addr,
  input  logic [DATA_WIDTH-1:0]    io_data,
  output logic                     io_ready,
  output logic                     cpu_stall,
  output logic                     busy,
  output logic                     we3,
  output logic [ADDRESS_WIDTH-1:0] ad3,
  output logic [DATA_WIDTH-1:0]    wd3
);

  localparam int WAIT_WIDTH = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [WAIT_WIDTH-1:0]    WAIT_MAX  = WAIT_WIDTH'(STARVE_LIMIT);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                   state_reg, state_next;
  logic [ADDRESS_WIDTH-1:0] clear_cnt_reg, clear_cnt_next;
  logic [WAIT_WIDTH-1:0]    wait_reg, wait_next;
  logic                     busy_reg, busy_next;
  logic                     we3_reg, we3_next;
  logic [ADDRESS_WIDTH-1:0] ad3_reg, ad3_next;
  logic [DATA_WIDTH-1:0]    wd3_reg, wd3_next;

  logic wb_req, io_req, force_io, io_grant, wb_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= CLEAR;
      clear_cnt_reg <= ADDRESS_WIDTH'(1);
      wait_reg      <= '0;
      busy_reg      <= 1'b1;
      we3_reg       <= 1'b0;
      ad3_reg       <= '0;
      wd3_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      clear_cnt_reg <= clear_cnt_next;
      wait_reg      <= wait_next;
      busy_reg      <= busy_next;
      we3_reg       <= we3_next;
      ad3_reg       <= ad3_next;
      wd3_reg       <= wd3_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    clear_cnt_next = clear_cnt_reg;
    wait_next      = wait_reg;
    busy_next      = busy_reg;
    we3_next       = 1'b0;
    ad3_next       = ad3_reg;
    wd3_next       = wd3_reg;
    io_ready       = 1'b0;
    cpu_stall      = 1'b1;
    wb_req         = wb_we && (wb_addr != '0);
    io_req         = io_valid && (io_addr != '0);
    force_io       = 1'b0;
    io_grant       = 1'b0;
    wb_grant       = 1'b0;

    case (state_reg)
      CLEAR: begin
        // busy stays high through the cycle that shows the final clear write
        busy_next      = 1'b1;
        we3_next       = 1'b1;
        ad3_next       = clear_cnt_reg;
        wd3_next       = '0;
        clear_cnt_next = clear_cnt_reg + ADDRESS_WIDTH'(1);
        wait_next      = '0;
        if (clear_cnt_reg == LAST_ADDR) state_next = RUN;
      end
      RUN: begin
        busy_next = 1'b0;
        force_io  = io_req && (wait_reg == WAIT_MAX);
        io_grant  = io_req && (!wb_req || force_io);
        wb_grant  = wb_req && !force_io;
        // an x0 request is acknowledged immediately and simply discarded
        io_ready  = io_valid && ((io_addr == '0) || io_grant);
        cpu_stall = force_io;
        wait_next = (io_req && !io_grant) ? wait_reg + WAIT_WIDTH'(1) : '0;
        if (io_grant) begin
          we3_next = 1'b1;
          ad3_next = io_addr;
          wd3_next = io_data;
        end else if (wb_grant) begin
          we3_next = 1'b1;
          ad3_next = wb_addr;
          wd3_next = wb_data;
        end
      end
      default: state_next = CLEAR;
    endcase

    if (rst) begin
      io_ready  = 1'b0;
      cpu_stall = 1'b1;
    end
  end

  assign busy = busy_reg;
  assign we3  = we3_reg;
  assign ad3  = ad3_reg;
  assign wd3  = wd3_reg;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus a
// randomized run checked against a cycle-level reference model.
module tb_regfile_write_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SL = 4;
  localparam int LAST = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          io_valid;
  logic [AW-1:0] io_addr;
  logic [DW-1:0] io_data;
  logic          io_ready;
  logic          cpu_stall;
  logic          busy;
  logic          we3;
  logic [AW-1:0] ad3;
  logic [DW-1:0] wd3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .io_valid(io_valid), .io_addr(io_addr), .io_data(io_data),
    .io_ready(io_ready), .cpu_stall(cpu_stall), .busy(busy),
    .we3(we3), .ad3(ad3), .wd3(wd3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    io_valid = 1'b0; io_addr = '0; io_data = '0;
  endtask

  // Expects CLEAR state on entry; walks the 31-write zero fill and the busy drop.
  task automatic check_clear_sequence(input string tag);
    wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h1234_5678;
    io_valid = 1'b1; io_addr = 5'd7; io_data = 32'h55;
    for (int k = 1; k <= LAST; k++) begin
      #1;
      n_cmp++;
      if ({cpu_stall, io_ready} !== 2'b10) begin
        n_bad++;
        $display("FAIL %s_clear_comb k=%0d: stall/ready=%b%b required 10", tag, k, cpu_stall, io_ready);
      end
      tick();
      if (k == LAST) idle_inputs();
      n_cmp++;
      if ({we3, ad3, wd3, busy} !== {1'b1, AW'(k), {DW{1'b0}}, 1'b1}) begin
        n_bad++;
        $display("FAIL %s_clear_write k=%0d: we3=%b ad3=%0d wd3=%h busy=%b required 1 %0d 0 1",
                 tag, k, we3, ad3, wd3, busy, k);
      end else
        $display("%s clear k=%0d ad3=%0d ok", tag, k, ad3);
    end
    tick();
    n_cmp++;
    if ({busy, we3, cpu_stall} !== 3'b000) begin
      n_bad++;
      $display("FAIL %s_clear_done: busy/we3/stall=%b%b%b required 000", tag, busy, we3, cpu_stall);
    end else
      $display("%s clear done, busy=0", tag);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    io_valid = 1'b1; io_addr = 5'd7; io_data = 32'hAA;
    tick();
    n_cmp++;
    if ({we3, ad3, wd3, busy, cpu_stall, io_ready} !== {1'b0, {AW{1'b0}}, {DW{1'b0}}, 3'b110}) begin
      n_bad++;
      $display("FAIL reset_state: we3=%b ad3=%0d wd3=%h busy=%b stall=%b ready=%b required 0 0 0 1 1 0",
               we3, ad3, wd3, busy, cpu_stall, io_ready);
    end else
      $display("reset state ok");
    rst = 1'b0;
    check_clear_sequence("reset");
  endtask

  task automatic test_wb_write();
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
    #1;
    n_cmp++;
    if ({cpu_stall, io_ready} !== 2'b00) begin
      n_bad++;
      $display("FAIL wb_comb: stall/ready=%b%b required 00", cpu_stall, io_ready);
    end
    tick();
    idle_inputs();
    n_cmp++;
    if ({we3, ad3, wd3} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
      n_bad++;
      $display("FAIL wb_write: we3=%b ad3=%0d wd3=%h required 1 5 deadbeef", we3, ad3, wd3);
    end else
      $display("wb write ad3=5 wd3=deadbeef ok");
    tick();
    n_cmp++;
    if ({we3, ad3, wd3} !== {1'b0, 5'd5, 32'hDEAD_BEEF}) begin
      n_bad++;
      $display("FAIL wb_hold: we3=%b ad3=%0d wd3=%h required 0 5 deadbeef", we3, ad3, wd3);
    end else
      $display("idle cycle holds ad3/wd3 ok");
  endtask

  task automatic test_starvation();
    wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
    io_valid = 1'b1; io_addr = 5'd31; io_data = 32'h1;
    for (int i = 0; i < SL; i++) begin
      #1;
      n_cmp++;
      if ({io_ready, cpu_stall} !== 2'b00) begin
        n_bad++;
        $display("FAIL starve_blocked i=%0d: ready/stall=%b%b required 00", i, io_ready, cpu_stall);
      end
      tick();
      n_cmp++;
      if ({we3, ad3, wd3} !== {1'b1, 5'd3, 32'h33}) begin
        n_bad++;
        $display("FAIL starve_wb i=%0d: we3=%b ad3=%0d wd3=%h required 1 3 33", i, we3, ad3, wd3);
      end else
        $display("starve cycle %0d: io blocked, wb ad3=3 written", i);
    end
    #1;
    n_cmp++;
    if ({io_ready, cpu_stall} !== 2'b11) begin
      n_bad++;
      $display("FAIL starve_force: ready/stall=%b%b required 11", io_ready, cpu_stall);
    end
    tick();
    io_valid = 1'b0;
    n_cmp++;
    if ({we3, ad3, wd3} !== {1'b1, 5'd31, 32'h1}) begin
      n_bad++;
      $display("FAIL starve_io_write: we3=%b ad3=%0d wd3=%h required 1 31 1", we3, ad3, wd3);
    end else
      $display("forced io write ad3=31 wd3=1 ok");
    tick();
    idle_inputs();
    n_cmp++;
    if ({we3, ad3, wd3} !== {1'b1, 5'd3, 32'h33}) begin
      n_bad++;
      $display("FAIL starve_wb_resume: we3=%b ad3=%0d wd3=%h required 1 3 33", we3, ad3, wd3);
    end else
      $display("wb resumes ad3=3 ok");
    tick();
  endtask

  task automatic test_x0();
    wb_we = 1'b1; wb_addr = '0; wb_data = 32'hFFFF_FFFF;
    tick();
    n_cmp++;
    if (we3 !== 1'b0) begin
      n_bad++;
      $display("FAIL x0_wb: we3=%b required 0", we3);
    end else
      $display("wb to x0 dropped ok");
    idle_inputs();
    io_valid = 1'b1; io_addr = '0; io_data = 32'hCAFE;
    #1;
    n_cmp++;
    if ({io_ready, cpu_stall} !== 2'b10) begin
      n_bad++;
      $display("FAIL x0_io_ready: ready/stall=%b%b required 10", io_ready, cpu_stall);
    end
    tick();
    idle_inputs();
    n_cmp++;
    if (we3 !== 1'b0) begin
      n_bad++;
      $display("FAIL x0_io: we3=%b required 0", we3);
    end else
      $display("io to x0 acked without write ok");
  endtask

  task automatic test_io_only();
    io_valid = 1'b1; io_addr = 5'd7; io_data = 32'hA5;
    #1;
    n_cmp++;
    if ({io_ready, cpu_stall} !== 2'b10) begin
      n_bad++;
      $display("FAIL io_only_ready: ready/stall=%b%b required 10", io_ready, cpu_stall);
    end
    tick();
    idle_inputs();
    n_cmp++;
    if ({we3, ad3, wd3} !== {1'b1, 5'd7, 32'hA5}) begin
      n_bad++;
      $display("FAIL io_only_write: we3=%b ad3=%0d wd3=%h required 1 7 a5", we3, ad3, wd3);
    end else
      $display("io write ad3=7 wd3=a5 ok");
  endtask

  // Reference model: an I/O write waits while a real CPU write competes, unless it
  // has already been refused SL times in a row; x0 targets never reach the file.
  task automatic test_random(input int n);
    int            blocked;
    logic [AW-1:0] last_ad;
    logic [DW-1:0] last_wd;
    logic          io_pend, held, wb_real, io_real, forced, exp_ready, exp_stall, exp_we;
    logic [AW-1:0] exp_ad;
    logic [DW-1:0] exp_wd;
    blocked = 0; last_ad = 5'd7; last_wd = 32'hA5; io_pend = 1'b0; held = 1'b0;
    for (int c = 0; c < n; c++) begin
      if (!held) begin
        wb_we   = ($urandom_range(0, 9) < 8);
        wb_addr = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
        wb_data = $urandom;
      end
      if (!io_pend) begin
        io_valid = ($urandom_range(0, 2) == 0);
        io_addr  = ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom);
        io_data  = $urandom;
      end
      wb_real   = wb_we && (wb_addr != 0);
      io_real   = io_valid && (io_addr != 0);
      forced    = io_real && (blocked == SL);
      exp_ready = io_valid && ((io_addr == 0) || !wb_real || forced);
      exp_stall = forced;
      if (io_real && exp_ready) begin
        exp_we = 1'b1; exp_ad = io_addr; exp_wd = io_data;
      end else if (wb_real) begin
        exp_we = 1'b1; exp_ad = wb_addr; exp_wd = wb_data;
      end else begin
        exp_we = 1'b0; exp_ad = last_ad; exp_wd = last_wd;
      end
      blocked = (io_real && !exp_ready) ? blocked + 1 : 0;
      #1;
      n_cmp++;
      if ({io_ready, cpu_stall} !== {exp_ready, exp_stall}) begin
        n_bad++;
        $display("FAIL rand_comb c=%0d: ready/stall=%b%b required %b%b", c, io_ready, cpu_stall, exp_ready, exp_stall);
      end
      tick();
      n_cmp++;
      if ({we3, ad3, wd3} !== {exp_we, exp_ad, exp_wd}) begin
        n_bad++;
        $display("FAIL rand_write c=%0d: we3=%b ad3=%0d wd3=%h required %b %0d %h", c, we3, ad3, wd3, exp_we, exp_ad, exp_wd);
      end else
        $display("rand c=%0d ready=%b stall=%b we3=%b ad3=%0d ok", c, exp_ready, exp_stall, exp_we, exp_ad);
      last_ad = exp_ad;
      last_wd = exp_wd;
      io_pend = io_valid && !exp_ready;
      held    = exp_stall;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_midclear();
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({we3, busy, ad3} !== {2'b01, {AW{1'b0}}}) begin
      n_bad++;
      $display("FAIL reset_midrun: we3=%b busy=%b ad3=%0d required 0 1 0", we3, busy, ad3);
    end else
      $display("reset from RUN ok");
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) tick();
    n_cmp++;
    if (ad3 !== 5'd9) begin
      n_bad++;
      $display("FAIL midclear_pos: ad3=%0d required 9", ad3);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({we3, busy, ad3} !== {2'b01, {AW{1'b0}}}) begin
      n_bad++;
      $display("FAIL reset_midclear: we3=%b busy=%b ad3=%0d required 0 1 0", we3, busy, ad3);
    end else
      $display("reset mid-clear ok");
    rst = 1'b0;
    check_clear_sequence("restart");
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_wb_write();
    test_starvation();
    test_x0();
    test_io_only();
    test_random(400);
    test_reset_midclear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
